// File: rtl/mac2_job_scheduler_pkg.sv
// rtl/mac2_job_scheduler_pkg.sv - shared state encoding and default widths for the MAC2 job scheduler
package mac2_sched_pkg;

  localparam int DEF_ADDR_WIDTH     = 8;
  localparam int DEF_COUNT_WIDTH    = 8;
  localparam int DEF_TIMEOUT_CYCLES = 64;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ISSUE,
    WAIT,
    ADVANCE,
    COMPLETE
  } state_e;

endpackage

// File: rtl/mac2_job_scheduler_if.sv
// rtl/mac2_job_scheduler_if.sv - control/address pins between the scheduler and one MAC2 unit
interface mac2_job_scheduler_if
  import mac2_sched_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

  logic                  mac_rst;
  logic                  mac_start;
  logic                  mac_done;
  logic [ADDR_WIDTH-1:0] mac_a_addr;
  logic [ADDR_WIDTH-1:0] mac_kernel_addr;
  logic [ADDR_WIDTH-1:0] mac_output_addr;

  modport master (
    output mac_rst, mac_start, mac_a_addr, mac_kernel_addr, mac_output_addr,
    input  mac_done
  );

  modport slave (
    input  mac_rst, mac_start, mac_a_addr, mac_kernel_addr, mac_output_addr,
    output mac_done
  );

endinterface

// File: rtl/mac2_job_scheduler_addr_gen.sv
// rtl/mac2_job_scheduler_addr_gen.sv - batch config latch, job counter and per-job address stepping
module mac2_sched_addr_gen
  import mac2_sched_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_load,
  input  logic                   i_advance,
  input  logic [ADDR_WIDTH-1:0]  i_a_base,
  input  logic [ADDR_WIDTH-1:0]  i_a_stride,
  input  logic [ADDR_WIDTH-1:0]  i_kernel_addr,
  input  logic [ADDR_WIDTH-1:0]  i_out_base,
  input  logic [COUNT_WIDTH-1:0] i_count,
  output logic [COUNT_WIDTH-1:0] o_job_idx,
  output logic [ADDR_WIDTH-1:0]  o_a_addr,
  output logic [ADDR_WIDTH-1:0]  o_kernel_addr,
  output logic [ADDR_WIDTH-1:0]  o_out_addr,
  output logic                   o_last
);

  localparam logic [ADDR_WIDTH-1:0]  A_ONE = ADDR_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] C_ONE = COUNT_WIDTH'(1);

  logic [ADDR_WIDTH-1:0]  r_stride;
  logic [COUNT_WIDTH-1:0] r_count;
  logic [COUNT_WIDTH-1:0] r_job_idx;
  logic [ADDR_WIDTH-1:0]  r_a_addr;
  logic [ADDR_WIDTH-1:0]  r_kernel_addr;
  logic [ADDR_WIDTH-1:0]  r_out_addr;

  // Address sums wrap naturally at ADDR_WIDTH bits.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stride      <= '0;
      r_count       <= '0;
      r_job_idx     <= '0;
      r_a_addr      <= '0;
      r_kernel_addr <= '0;
      r_out_addr    <= '0;
    end else if (i_load) begin
      r_stride      <= i_a_stride;
      r_count       <= i_count;
      r_job_idx     <= '0;
      r_a_addr      <= i_a_base;
      r_kernel_addr <= i_kernel_addr;
      r_out_addr    <= i_out_base;
    end else if (i_advance) begin
      r_job_idx  <= r_job_idx + C_ONE;
      r_a_addr   <= r_a_addr + r_stride;
      r_out_addr <= r_out_addr + A_ONE;
    end
  end

  assign o_job_idx     = r_job_idx;
  assign o_a_addr      = r_a_addr;
  assign o_kernel_addr = r_kernel_addr;
  assign o_out_addr    = r_out_addr;
  assign o_last        = (r_job_idx == (r_count - C_ONE));

endmodule

// File: rtl/mac2_job_scheduler.sv
// rtl/mac2_job_scheduler.sv - sequences a batch of jobs on one MAC2 unit (CLEAR/ISSUE/WAIT/ADVANCE per job)
// Optional per-job WAIT timeout with sticky err: define MAC2_SCHED_TIMEOUT_EN.
module mac2_job_scheduler
  import mac2_sched_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int COUNT_WIDTH    = DEF_COUNT_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_cfg_start,
  input  logic [ADDR_WIDTH-1:0]  i_cfg_a_base,
  input  logic [ADDR_WIDTH-1:0]  i_cfg_a_stride,
  input  logic [ADDR_WIDTH-1:0]  i_cfg_kernel_addr,
  input  logic [ADDR_WIDTH-1:0]  i_cfg_out_base,
  input  logic [COUNT_WIDTH-1:0] i_cfg_count,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_err,
  output logic [COUNT_WIDTH-1:0] o_job_idx,
  mac2_job_scheduler_if.master   mac
);

  state_e                r_state;
  state_e                w_next_state;
  logic                  w_load;
  logic                  w_advance;
  logic                  w_last;
  logic                  w_timeout;
  logic [ADDR_WIDTH-1:0] w_a_addr;
  logic [ADDR_WIDTH-1:0] w_kernel_addr;
  logic [ADDR_WIDTH-1:0] w_out_addr;

  assign w_load    = (r_state == IDLE) && i_cfg_start;
  assign w_advance = (r_state == ADVANCE) && !w_last;

  mac2_sched_addr_gen #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .COUNT_WIDTH (COUNT_WIDTH)
  ) u_addr_gen (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_load        (w_load),
    .i_advance     (w_advance),
    .i_a_base      (i_cfg_a_base),
    .i_a_stride    (i_cfg_a_stride),
    .i_kernel_addr (i_cfg_kernel_addr),
    .i_out_base    (i_cfg_out_base),
    .i_count       (i_cfg_count),
    .o_job_idx     (o_job_idx),
    .o_a_addr      (w_a_addr),
    .o_kernel_addr (w_kernel_addr),
    .o_out_addr    (w_out_addr),
    .o_last        (w_last)
  );

`ifdef MAC2_SCHED_TIMEOUT_EN
  localparam int WCW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WCW-1:0] r_wait_cnt;
  logic           r_err;

  // Fires on the last permitted WAIT cycle so exactly TIMEOUT_CYCLES WAIT cycles elapse.
  assign w_timeout = (r_state == WAIT) && !mac.mac_done &&
                     (r_wait_cnt == WCW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wait_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      r_wait_cnt <= (r_state == WAIT) ? r_wait_cnt + WCW'(1) : '0;
      if (w_load)
        r_err <= 1'b0;
      else if (w_timeout)
        r_err <= 1'b1;
    end
  end

  assign o_err = r_err;
`else
  assign w_timeout = 1'b0;
  assign o_err     = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_state <= IDLE;
    else
      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:     if (i_cfg_start) w_next_state = (i_cfg_count == '0) ? COMPLETE : CLEAR;
      CLEAR:    w_next_state = ISSUE;
      ISSUE:    w_next_state = WAIT;
      WAIT: begin
        if (mac.mac_done)
          w_next_state = ADVANCE;
        else if (w_timeout)
          w_next_state = COMPLETE;
      end
      ADVANCE:  w_next_state = w_last ? COMPLETE : CLEAR;
      COMPLETE: w_next_state = IDLE;
      default:  w_next_state = IDLE;
    endcase
  end

  always_comb begin
    o_busy        = (r_state != IDLE);
    o_done        = (r_state == COMPLETE);
    mac.mac_rst   = (r_state == CLEAR);
    mac.mac_start = (r_state == ISSUE);
  end

  assign mac.mac_a_addr      = w_a_addr;
  assign mac.mac_kernel_addr = w_kernel_addr;
  assign mac.mac_output_addr = w_out_addr;

endmodule

// File: tb/tb_mac2_job_scheduler.sv
// tb/tb_mac2_job_scheduler.sv - directed self-checking bench for mac2_job_scheduler with a MAC2 unit model
module tb_mac2_job_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_start = 1'b0;
  logic [7:0] cfg_a_base = '0, cfg_a_stride = '0, cfg_kernel = '0, cfg_out_base = '0, cfg_count = '0;
  logic       busy, done, err;
  logic [7:0] job_idx;
  bit         mdl_hang = 1'b0;

  int checks = 0;
  int errors = 0;

  mac2_job_scheduler_if #(.ADDR_WIDTH(8)) mac_if ();

  mac2_job_scheduler #(
    .ADDR_WIDTH     (8),
    .COUNT_WIDTH    (8),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_cfg_start       (cfg_start),
    .i_cfg_a_base      (cfg_a_base),
    .i_cfg_a_stride    (cfg_a_stride),
    .i_cfg_kernel_addr (cfg_kernel),
    .i_cfg_out_base    (cfg_out_base),
    .i_cfg_count       (cfg_count),
    .o_busy            (busy),
    .o_done            (done),
    .o_err             (err),
    .o_job_idx         (job_idx),
    .mac               (mac_if)
  );

  always #5 clk = ~clk;

  // Unit model: level done raised a few cycles after start, cleared by its reset.
  logic [3:0] m_cnt;
  always @(posedge clk) begin
    if (rst || mac_if.mac_rst) begin
      m_cnt           <= '0;
      mac_if.mac_done <= 1'b0;
    end else if (mac_if.mac_start) begin
      m_cnt <= 4'd4;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 4'd1;
      if (m_cnt == 4'd1 && !mdl_hang) mac_if.mac_done <= 1'b1;
    end
  end

  int         n_start = 0, n_rst = 0, n_done = 0, n_seq_bad = 0, n_unstable = 0;
  logic [7:0] a_log [64];
  logic [7:0] o_log [64];
  logic [7:0] k_log [64];
  bit         prev_rst = 1'b0;

  always @(posedge clk) begin
    if (!rst) begin
      if (mac_if.mac_rst) n_rst++;
      if (mac_if.mac_start && n_start < 64) begin
        if (!prev_rst) n_seq_bad++;
        a_log[n_start] = mac_if.mac_a_addr;
        o_log[n_start] = mac_if.mac_output_addr;
        k_log[n_start] = mac_if.mac_kernel_addr;
        n_start++;
      end
      if (done) n_done++;
      if (m_cnt == 4'd1 && n_start > 0) begin
        if (mac_if.mac_a_addr != a_log[n_start-1] || mac_if.mac_output_addr != o_log[n_start-1] ||
            mac_if.mac_kernel_addr != k_log[n_start-1])
          n_unstable++;
      end
    end
    prev_rst = mac_if.mac_rst;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic start_batch(input logic [7:0] a, input logic [7:0] s, input logic [7:0] k,
                             input logic [7:0] o, input logic [7:0] c);
    cfg_a_base = a; cfg_a_stride = s; cfg_kernel = k; cfg_out_base = o; cfg_count = c;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok, output int cyc);
    ok = 1'b0; cyc = 0;
    for (int i = 1; i <= budget; i++) begin
      if (done) begin ok = 1'b1; cyc = i; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_starts(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (n_start >= target) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic chk_jobs(input string tag, input int base, input logic [7:0] a0, input logic [7:0] s,
                          input logic [7:0] k, input logic [7:0] o0, input int n);
    logic [7:0] ea, eo;
    ea = a0; eo = o0;
    for (int j = 0; j < n; j++) begin
      chk($sformatf("%s_a%0d", tag, j), 32'(a_log[base+j]), 32'(ea));
      chk($sformatf("%s_o%0d", tag, j), 32'(o_log[base+j]), 32'(eo));
      chk($sformatf("%s_k%0d", tag, j), 32'(k_log[base+j]), 32'(k));
      ea = ea + s;
      eo = eo + 8'd1;
    end
  endtask

  initial begin
    bit ok;
    int cyc, bs, br, bd;

    step(3);
    rst = 1'b0;
    step(1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_job_idx", 32'(job_idx), 0);
    chk("rst_mac_rst", 32'(mac_if.mac_rst), 0);
    chk("rst_mac_start", 32'(mac_if.mac_start), 0);
    chk("rst_addrs", {8'h0, mac_if.mac_a_addr, mac_if.mac_kernel_addr, mac_if.mac_output_addr}, 0);

    // Basic three-job sweep: 8 cycles per job then COMPLETE.
    bs = n_start; br = n_rst; bd = n_done;
    start_batch(8'h10, 8'h04, 8'h40, 8'h80, 8'd3);
    chk("t1_busy", 32'(busy), 1);
    wait_done(200, ok, cyc);
    chk("t1_done_seen", 32'(ok), 1);
    chk("t1_latency", 32'(cyc), 25);
    chk("t1_err", 32'(err), 0);
    step(2);
    chk("t1_starts", 32'(n_start - bs), 3);
    chk("t1_clears", 32'(n_rst - br), 3);
    chk("t1_done_pulses", 32'(n_done - bd), 1);
    chk("t1_busy_after", 32'(busy), 0);
    chk("t1_hold_idx", 32'(job_idx), 2);
    chk("t1_hold_a", 32'(mac_if.mac_a_addr), 32'h18);
    chk("t1_hold_o", 32'(mac_if.mac_output_addr), 32'h82);
    chk_jobs("t1", bs, 8'h10, 8'h04, 8'h40, 8'h80, 3);

    // Zero-length batch.
    bs = n_start; br = n_rst; bd = n_done;
    start_batch(8'h33, 8'h01, 8'h44, 8'h55, 8'd0);
    chk("t2_done", 32'(done), 1);
    chk("t2_busy", 32'(busy), 1);
    chk("t2_a_latched", 32'(mac_if.mac_a_addr), 32'h33);
    step(1);
    chk("t2_done_after", 32'(done), 0);
    chk("t2_busy_after", 32'(busy), 0);
    chk("t2_no_start", 32'(n_start - bs), 0);
    chk("t2_no_clear", 32'(n_rst - br), 0);
    chk("t2_done_pulses", 32'(n_done - bd), 1);

    // Address wrap-around.
    bs = n_start;
    start_batch(8'hFE, 8'h02, 8'h40, 8'hFF, 8'd3);
    wait_done(200, ok, cyc);
    chk("t3_done_seen", 32'(ok), 1);
    step(1);
    chk("t3_starts", 32'(n_start - bs), 3);
    chk_jobs("t3", bs, 8'hFE, 8'h02, 8'h40, 8'hFF, 3);

    // cfg_start during job 1 WAIT must be ignored.
    bs = n_start;
    start_batch(8'h20, 8'h03, 8'h55, 8'h30, 8'd3);
    wait_starts(bs + 2, 200, ok);
    chk("t4_reach_job1", 32'(ok), 1);
    step(2);
    cfg_a_base = 8'h99; cfg_a_stride = 8'h11; cfg_kernel = 8'h77; cfg_out_base = 8'h66; cfg_count = 8'd9;
    cfg_start = 1'b1;
    step(1);
    cfg_start = 1'b0;
    wait_done(200, ok, cyc);
    chk("t4_done_seen", 32'(ok), 1);
    step(3);
    chk("t4_starts", 32'(n_start - bs), 3);
    chk("t4_idle_after", 32'(busy), 0);
    chk_jobs("t4", bs, 8'h20, 8'h03, 8'h55, 8'h30, 3);

    // Reset during job 2 WAIT aborts with no done, then a fresh batch starts at job 0.
    bs = n_start;
    start_batch(8'h10, 8'h04, 8'h40, 8'h80, 8'd3);
    wait_starts(bs + 3, 200, ok);
    chk("t5_reach_job2", 32'(ok), 1);
    step(1);
    bd = n_done;
    rst = 1'b1;
    step(1);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_done", 32'(done), 0);
    chk("t5_err", 32'(err), 0);
    chk("t5_job_idx", 32'(job_idx), 0);
    chk("t5_ctl", {30'h0, mac_if.mac_rst, mac_if.mac_start}, 0);
    chk("t5_addrs", {8'h0, mac_if.mac_a_addr, mac_if.mac_kernel_addr, mac_if.mac_output_addr}, 0);
    rst = 1'b0;
    step(2);
    chk("t5_no_done", 32'(n_done - bd), 0);
    bs = n_start;
    start_batch(8'h10, 8'h04, 8'h40, 8'h80, 8'd2);
    wait_done(200, ok, cyc);
    chk("t5_rerun_latency", 32'(cyc), 17);
    step(1);
    chk("t5_rerun_starts", 32'(n_start - bs), 2);
    chk_jobs("t5", bs, 8'h10, 8'h04, 8'h40, 8'h80, 2);

`ifdef MAC2_SCHED_TIMEOUT_EN
    // Hung unit: 8 WAIT cycles then COMPLETE with err, remaining jobs skipped.
    bs = n_start;
    mdl_hang = 1'b1;
    start_batch(8'h10, 8'h04, 8'h40, 8'h80, 8'd4);
    wait_done(200, ok, cyc);
    chk("t6_done_seen", 32'(ok), 1);
    chk("t6_latency", 32'(cyc), 11);
    chk("t6_err", 32'(err), 1);
    step(3);
    chk("t6_err_sticky", 32'(err), 1);
    chk("t6_starts", 32'(n_start - bs), 1);
    mdl_hang = 1'b0;
    start_batch(8'h10, 8'h04, 8'h40, 8'h80, 8'd1);
    chk("t6_err_cleared", 32'(err), 0);
    wait_done(200, ok, cyc);
    chk("t6_rerun_err", 32'(err), 0);
    step(1);
`endif

    chk("seq_clear_before_start", 32'(n_seq_bad), 0);
    chk("addr_stable_in_wait", 32'(n_unstable), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac2_job_scheduler.md
Name: mac2_job_scheduler

Overview:
Sequences a batch of MAC2 jobs on one memory-attached MAC2 unit. Typical use is a 1-D convolution sweep: a strided input window, a fixed kernel and consecutive output words.
- Per job: resets the unit, pulses start, holds all three addresses stable, waits for done, then advances.
- Sits between the top-level control FSM (cfg_* interface) and the MAC2 unit's start/done/address pins. It never touches the memory buses.

Parameters:
ADDR_WIDTH, 8, width of all memory addresses; address arithmetic wraps mod 2^ADDR_WIDTH
COUNT_WIDTH, 8, width of job count and job index
TIMEOUT_CYCLES, 64, max WAIT cycles per job (used only with the optional feature)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
cfg_start  input  1  one-cycle request to begin a batch; sampled only in IDLE
cfg_a_base  input  ADDR_WIDTH  address of first input word
cfg_a_stride  input  ADDR_WIDTH  input address increment per job
cfg_kernel_addr  input  ADDR_WIDTH  kernel address, constant over batch
cfg_out_base  input  ADDR_WIDTH  first output address; increments by 1 per job
cfg_count  input  COUNT_WIDTH  number of jobs; 0 is legal
busy  output  1  high from cycle after accepted cfg_start until COMPLETE inclusive
done  output  1  one-cycle pulse at batch end
err  output  1  timeout flag, valid with done (tied 0 without feature)
job_idx  output  COUNT_WIDTH  index of current job
mac_rst  output  1  per-job reset to MAC2 unit (OR'd with system rst at top)
mac_start  output  1  start pulse to MAC2 unit
mac_a_addr  output  ADDR_WIDTH  input operand address to unit
mac_kernel_addr  output  ADDR_WIDTH  kernel address to unit
mac_output_addr  output  ADDR_WIDTH  result address to unit
mac_done  input  1  MAC2 done; level, stays high until unit reset

Behaviour:
- Reset values: all outputs 0, state IDLE, job counter 0. Reset mid-batch aborts immediately with no done pulse.
- cfg_* inputs are latched on accept. Later changes have no effect until the next batch.
- IDLE: if cfg_start, latch cfg_*, job_idx<=0, mac_a_addr<=cfg_a_base, mac_kernel_addr<=cfg_kernel_addr, mac_output_addr<=cfg_out_base.
  - If cfg_count==0, go to COMPLETE; otherwise go to CLEAR.
- CLEAR (1 cycle): mac_rst=1. This clears the unit's sticky done from the previous job. Next state ISSUE.
- ISSUE (1 cycle): mac_rst=0, mac_start=1. Next state WAIT.
- WAIT: mac_start=0. mac_done is sampled only here.
  - When mac_done=1, go to ADVANCE.
  - Addresses must stay stable throughout, because the unit samples the kernel and output addresses several cycles after start.
- ADVANCE (1 cycle):
  - If job_idx==count-1, go to COMPLETE.
  - Else job_idx+=1, mac_a_addr+=stride, mac_output_addr+=1 (both mod 2^ADDR_WIDTH), then go to CLEAR.
- COMPLETE (1 cycle): done=1, busy=1, then go to IDLE.
- cfg_start outside IDLE is ignored (no queueing). cfg_start in the cycle COMPLETE returns to IDLE is also ignored; it is accepted only when sampled in IDLE.
- Per-job overhead is 3 cycles (CLEAR, ISSUE, ADVANCE) plus the unit latency.
- job_idx, mac_* addresses hold their final values after COMPLETE until the next accept.
- Outputs are registered. mac_rst and mac_start are Moore outputs decoded from registered state.

Optional Feature:
Macro MAC2_SCHED_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entering WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without mac_done, the scheduler sets err=1 (sticky until next accept), skips the remaining jobs and goes to COMPLETE.
  - err clears on accept.
- Undefined: no counter, err tied 0, WAIT waits indefinitely.

Decomposition:
- Package mac2_sched_pkg: state enum (IDLE, CLEAR, ISSUE, WAIT, ADVANCE, COMPLETE), default width localparams.
- One natural sub-module, mac2_sched_addr_gen. It holds the latched bases, stride and job counter, with load/advance strobes and a last-job flag.
- The FSM stays in the top module.

Test Plan:
- count=3, a_base=0x10, stride=4, kernel=0x40, out_base=0x80, unit model done 5 cycles after start → three mac_start pulses; (a,out) = (0x10,0x80), (0x14,0x81), (0x18,0x82); kernel always 0x40; mac_rst before each start; one done pulse, err=0.
- count=0 → no mac_rst or mac_start; done pulses 1 cycle after accept; busy high exactly that cycle.
- Wrap-around: a_base=0xFE, stride=2, out_base=0xFF, count=3 → a addresses 0xFE, 0x00, 0x02; out addresses 0xFF, 0x00, 0x01.
- cfg_start pulsed during WAIT of job 1 with different cfg values → ignored; batch completes with original addresses; no extra start.
- rst asserted during WAIT of job 2 → next cycle all outputs 0, state IDLE, no done. A fresh cfg_start runs a full batch from job 0.
- (MAC2_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=8) unit never asserts done on job 0 of a count=4 batch → done+err after 8 WAIT cycles, no further mac_start, err clears on next accept.
